// File: rtl/fft_pkg.sv
// Shared types and constants for the xfft streaming front end.
package fft_pkg;
  typedef enum logic {
    CFG = 1'b0,
    RUN = 1'b1
  } fft_state_e;

  localparam int CFG_DIR_BIT = 0;
  localparam int CFG_WIDTH   = 8;
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head entry is always on dout.
module sync_fifo_fwft #(
  parameter int DATAWIDTH = 48,
  parameter int DEPTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATAWIDTH-1:0] din,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output logic [DATAWIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [DATAWIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/fft_stream_framer.sv
// Framing, config handshake and bin indexing around an externally wired xfft core.
//   state | meaning
//   CFG   | presenting direction word on the config channel, data path held off
//   RUN   | streaming FIFO contents to the core, tlast every FFT_LEN beats
module fft_stream_framer
  import fft_pkg::*;
#(
  parameter int DATAWIDTH  = 48,
  parameter int LOG2_LEN   = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fwd_inv,
  input  logic [DATAWIDTH-1:0] sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic [CFG_WIDTH-1:0] cfg_tdata,
  output logic                 cfg_tvalid,
  input  logic                 cfg_tready,
  output logic [DATAWIDTH-1:0] fft_s_tdata,
  output logic                 fft_s_tvalid,
  input  logic                 fft_s_tready,
  output logic                 fft_s_tlast,
  input  logic [DATAWIDTH-1:0] fft_m_tdata,
  input  logic                 fft_m_tvalid,
  output logic                 fft_m_tready,
  input  logic                 fft_m_tlast,
  output logic [DATAWIDTH-1:0] bin_out,
  output logic                 bin_valid,
  input  logic                 bin_ready,
  output logic [LOG2_LEN-1:0]  bin_index,
  output logic                 bin_last,
  output logic [15:0]          frame_count,
  output logic                 overflow,
  output logic                 err_tlast
);
  localparam logic [LOG2_LEN-1:0] LAST_IDX = '1;

  fft_state_e          state_q, state_d;
  logic                mode_q, mode_d;
  logic [LOG2_LEN-1:0] in_idx_q, in_idx_d;
  logic [LOG2_LEN-1:0] out_idx_q, out_idx_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                overflow_q, overflow_d;
  logic                err_tlast_q, err_tlast_d;
  logic                fifo_full, fifo_empty;
  logic                s_hs, m_hs;

  sync_fifo_fwft #(
    .DATAWIDTH(DATAWIDTH),
    .DEPTH    (FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (sample_valid && !fifo_full),
    .din  (sample_in),
    .pop  (s_hs),
    .full (fifo_full),
    .empty(fifo_empty),
    .dout (fft_s_tdata)
  );

  assign sample_ready = !fifo_full;
  assign fft_s_tlast  = (in_idx_q == LAST_IDX);

  always_comb begin
    cfg_tdata              = '0;
    cfg_tdata[CFG_DIR_BIT] = mode_q;
  end

  assign bin_out      = fft_m_tdata;
  assign bin_valid    = fft_m_tvalid;
  assign fft_m_tready = bin_ready;
  assign bin_index    = out_idx_q;
  assign bin_last     = (out_idx_q == LAST_IDX);
  assign m_hs         = fft_m_tvalid && bin_ready;

  assign frame_count = frame_count_q;
  assign overflow    = overflow_q;
  assign err_tlast   = err_tlast_q;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    in_idx_d      = in_idx_q;
    out_idx_d     = out_idx_q;
    frame_count_d = frame_count_q;
    overflow_d    = overflow_q;
    err_tlast_d   = err_tlast_q;
    cfg_tvalid    = 1'b0;
    fft_s_tvalid  = 1'b0;
    s_hs          = 1'b0;

    case (state_q)
      CFG: begin
        cfg_tvalid = !rst;
        if (cfg_tready) state_d = RUN;
      end
      RUN: begin
        fft_s_tvalid = !fifo_empty && !rst;
        s_hs         = fft_s_tvalid && fft_s_tready;
        // Direction changes only land between frames so a frame is never split.
        if ((in_idx_q == '0) && !s_hs && (fwd_inv != mode_q)) begin
          mode_d  = fwd_inv;
          state_d = CFG;
        end
      end
      default: state_d = CFG;
    endcase

    if (s_hs) in_idx_d = in_idx_q + LOG2_LEN'(1);
    if (sample_valid && fifo_full) overflow_d = 1'b1;

    if (m_hs) begin
      out_idx_d = out_idx_q + LOG2_LEN'(1);
      if (bin_last) frame_count_d = frame_count_q + 16'd1;
      if (fft_m_tlast != bin_last) err_tlast_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= CFG;
      mode_q        <= fwd_inv;
      in_idx_q      <= '0;
      out_idx_q     <= '0;
      frame_count_q <= '0;
      overflow_q    <= 1'b0;
      err_tlast_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      in_idx_q      <= in_idx_d;
      out_idx_q     <= out_idx_d;
      frame_count_q <= frame_count_d;
      overflow_q    <= overflow_d;
      err_tlast_q   <= err_tlast_d;
    end
  end
endmodule

// File: tb/tb_fft_stream_framer.sv
// Scoreboard bench for fft_stream_framer with an 8-point frame and 4-entry FIFO.
module tb_fft_stream_framer;
  localparam int DW = 16;
  localparam int LG = 3;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fwd_inv;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic          sample_ready;
  logic [7:0]    cfg_tdata;
  logic          cfg_tvalid;
  logic          cfg_tready;
  logic [DW-1:0] fft_s_tdata;
  logic          fft_s_tvalid;
  logic          fft_s_tready;
  logic          fft_s_tlast;
  logic [DW-1:0] fft_m_tdata;
  logic          fft_m_tvalid;
  logic          fft_m_tready;
  logic          fft_m_tlast;
  logic [DW-1:0] bin_out;
  logic          bin_valid;
  logic          bin_ready;
  logic [LG-1:0] bin_index;
  logic          bin_last;
  logic [15:0]   frame_count;
  logic          overflow;
  logic          err_tlast;

  fft_stream_framer #(.DATAWIDTH(DW), .LOG2_LEN(LG), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .fwd_inv(fwd_inv),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
    .fft_s_tdata(fft_s_tdata), .fft_s_tvalid(fft_s_tvalid), .fft_s_tready(fft_s_tready),
    .fft_s_tlast(fft_s_tlast),
    .fft_m_tdata(fft_m_tdata), .fft_m_tvalid(fft_m_tvalid), .fft_m_tready(fft_m_tready),
    .fft_m_tlast(fft_m_tlast),
    .bin_out(bin_out), .bin_valid(bin_valid), .bin_ready(bin_ready),
    .bin_index(bin_index), .bin_last(bin_last), .frame_count(frame_count),
    .overflow(overflow), .err_tlast(err_tlast)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] data; logic last; } s_exp_t;
  typedef struct { logic [7:0] data; int beats; } cfg_exp_t;
  typedef struct { logic [DW-1:0] data; logic [LG-1:0] idx; logic last; logic [15:0] fc; logic err; } bin_exp_t;

  s_exp_t   sq[$];
  cfg_exp_t cq[$];
  bin_exp_t bq[$];

  int checks = 0;
  int errors = 0;
  int beats  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations on every handshake; also checks stall stability.
  logic          stall_seen = 1'b0;
  logic [DW-1:0] stall_data;
  logic          stall_last;
  s_exp_t        m_s;
  cfg_exp_t      m_c;
  bin_exp_t      m_b;

  always @(negedge clk) begin
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      if (cfg_tvalid && cfg_tready) begin
        if (cq.size() == 0) begin
          checks++; errors++;
          $display("FAIL cfg_unexpected: got cfg_tdata %0h with no handshake expected", cfg_tdata);
        end else begin
          m_c = cq.pop_front();
          check("cfg_tdata", cfg_tdata, m_c.data);
          check("cfg_after_beats", beats, m_c.beats);
        end
      end
      if (fft_s_tvalid && stall_seen) begin
        check("stall_tdata_stable", fft_s_tdata, stall_data);
        check("stall_tlast_stable", fft_s_tlast, stall_last);
      end
      if (fft_s_tvalid && fft_s_tready) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL s_unexpected: got beat %0h with none expected", fft_s_tdata);
        end else begin
          m_s = sq.pop_front();
          check("s_tdata", fft_s_tdata, m_s.data);
          check("s_tlast", fft_s_tlast, m_s.last);
        end
        beats++;
      end
      stall_seen = fft_s_tvalid && !fft_s_tready;
      stall_data = fft_s_tdata;
      stall_last = fft_s_tlast;
      if (fft_m_tvalid && bin_ready) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL bin_unexpected: got bin %0h with none expected", bin_out);
        end else begin
          m_b = bq.pop_front();
          check("bin_out", bin_out, m_b.data);
          check("bin_index", bin_index, m_b.idx);
          check("bin_last", bin_last, m_b.last);
          check("bin_frame_count", frame_count, m_b.fc);
          check("bin_err_tlast", err_tlast, m_b.err);
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sq.size() + cq.size() + bq.size()) != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if ((sq.size() + cq.size() + bq.size()) != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout: got %0d/%0d/%0d pending expected 0", name,
               sq.size(), cq.size(), bq.size());
    end
  endtask

  // Push n samples base.. back to back; idx0 is the frame position of the first.
  task automatic stream(input logic [DW-1:0] base, input int n, input int idx0,
                        input int flip_at, input bit chk_first);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      sample_in    = base + DW'(j);
      sample_valid = 1'b1;
      sq.push_back(s_exp_t'{data: base + DW'(j), last: ((idx0 + j) % 8) == 7});
      if (j == flip_at) fwd_inv = 1'b0;
      if (chk_first && j == 0) begin
        @(negedge clk);
        check("no_bypass_tvalid", fft_s_tvalid, 1'b0);
      end
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  // Present n bins with bin_ready toggling 0,1 each cycle; err_after: last bin with clean err flag.
  task automatic drive_bins(input int n, input int tlast_pos, input logic [DW-1:0] base,
                            input logic [15:0] fc0, input int err_after);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      fft_m_tvalid = 1'b1;
      fft_m_tdata  = base + DW'(k);
      fft_m_tlast  = (k == tlast_pos);
      bin_ready    = 1'b0;
      bq.push_back(bin_exp_t'{data: base + DW'(k), idx: k[LG-1:0], last: (k == 7),
                              fc: fc0, err: (k > err_after)});
      @(posedge clk); #1;
      bin_ready = 1'b1;
    end
    @(posedge clk); #1;
    fft_m_tvalid = 1'b0;
    fft_m_tlast  = 1'b0;
    bin_ready    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish within 200000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; fwd_inv = 1'b1; sample_in = '0; sample_valid = 1'b0;
    cfg_tready = 1'b0; fft_s_tready = 1'b0;
    fft_m_tdata = '0; fft_m_tvalid = 1'b0; fft_m_tlast = 1'b0; bin_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cfg_tvalid", cfg_tvalid, 1'b0);
    check("rst_s_tvalid", fft_s_tvalid, 1'b0);
    cq.push_back(cfg_exp_t'{data: 8'h01, beats: 0});
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("cfg_tvalid_after_rst", cfg_tvalid, 1'b1);
    check("cfg_tdata_after_rst", cfg_tdata, 8'h01);
    check("s_tvalid_in_cfg", fft_s_tvalid, 1'b0);
    check("sample_ready_after_rst", sample_ready, 1'b1);
    check("overflow_after_rst", overflow, 1'b0);
    check("err_tlast_after_rst", err_tlast, 1'b0);
    check("frame_count_after_rst", frame_count, 16'd0);
    check("bin_index_after_rst", bin_index, 3'd0);
    @(posedge clk); #1;
    cfg_tready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("cfg_tvalid_in_run", cfg_tvalid, 1'b0);
    check("s_tvalid_run_empty", fft_s_tvalid, 1'b0);

    // Samples 1..16 streamed straight through.
    fft_s_tready = 1'b1;
    stream(16'd1, 16, 0, -1, 1'b1);
    wait_drain("stream16");
    check("overflow_clean", overflow, 1'b0);

    // Stall with six pushes into a four-entry FIFO.
    @(posedge clk); #1;
    fft_s_tready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      sample_in    = DW'(100 + k);
      sample_valid = 1'b1;
      if (k <= 4) sq.push_back(s_exp_t'{data: DW'(100 + k), last: 1'b0});
      @(negedge clk);
      check("stall_sample_ready", sample_ready, (k <= 4));
    end
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(negedge clk);
    check("overflow_set", overflow, 1'b1);
    check("stall_s_tvalid", fft_s_tvalid, 1'b1);
    check("stall_head_data", fft_s_tdata, 16'd101);
    repeat (3) @(posedge clk);
    #1;
    fft_s_tready = 1'b1;
    wait_drain("stall");
    stream(16'd201, 4, 4, -1, 1'b0);
    wait_drain("frame3_tail");

    // Direction flips mid-frame; config must wait for the eighth beat.
    cq.push_back(cfg_exp_t'{data: 8'h00, beats: 32});
    stream(16'd301, 8, 0, 3, 1'b0);
    wait_drain("mode_change");
    stream(16'd401, 8, 0, -1, 1'b0);
    wait_drain("post_mode_frame");
    check("cfg_idle_after_change", cfg_tvalid, 1'b0);

    // Output bins: clean frame, then tlast early on the fifth bin.
    drive_bins(8, 7, 16'h500, 16'd0, 99);
    wait_drain("bins1");
    @(negedge clk);
    check("frame_count_1", frame_count, 16'd1);
    check("err_tlast_clean", err_tlast, 1'b0);
    check("bin_index_wrapped", bin_index, 3'd0);
    drive_bins(8, 4, 16'h600, 16'd1, 4);
    wait_drain("bins2");
    @(negedge clk);
    check("frame_count_2", frame_count, 16'd2);
    check("err_tlast_sticky", err_tlast, 1'b1);

    // Reset in the middle of both input and output frames.
    fft_s_tready = 1'b0;
    stream(16'd901, 3, 0, -1, 1'b0);
    void'(sq.pop_back()); void'(sq.pop_back()); void'(sq.pop_back());
    drive_bins(3, -1, 16'h700, 16'd2, -1);
    wait_drain("pre_reset");
    cq.push_back(cfg_exp_t'{data: 8'h00, beats: beats});
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_s_tvalid", fft_s_tvalid, 1'b0);
    check("midrst_cfg_tvalid", cfg_tvalid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    fft_s_tready = 1'b1;
    @(negedge clk);
    check("midrst_frame_count", frame_count, 16'd0);
    check("midrst_overflow", overflow, 1'b0);
    check("midrst_err_tlast", err_tlast, 1'b0);
    check("midrst_bin_index", bin_index, 3'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_fifo_flushed", fft_s_tvalid, 1'b0);
    stream(16'd801, 8, 0, -1, 1'b0);
    wait_drain("post_reset_frame");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_stream_framer.md
Name: fft_stream_framer

Overview:
- Framing and flow-control front end for the Xilinx xfft core in the vocoder datapath.
- Buffers free-running audio samples in a FWFT FIFO, issues the core's config handshake (forward/inverse), feeds samples with proper valid/ready and tlast every FFT_LEN beats, and indexes output bins.
- Flags overflow and tlast mismatch; the core itself is instantiated by the parent and wired to the fft_* ports.

Parameters:
DATAWIDTH, 48, sample/bin width (re/im packed as the core expects)
LOG2_LEN, 10, log2 of FFT frame length (FFT_LEN = 2**LOG2_LEN)
FIFO_DEPTH, 16, input FIFO entries, power of two, >= 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
fwd_inv  in  1  requested direction, 1 = forward, 0 = inverse
sample_in  in  DATAWIDTH  audio sample
sample_valid  in  1  sample present this cycle
sample_ready  out  1  FIFO not full
cfg_tdata  out  8  to core s_axis_config_tdata
cfg_tvalid  out  1  to core s_axis_config_tvalid
cfg_tready  in  1  from core
fft_s_tdata  out  DATAWIDTH  to core s_axis_data_tdata
fft_s_tvalid  out  1
fft_s_tready  in  1
fft_s_tlast  out  1
fft_m_tdata  in  DATAWIDTH  from core m_axis_data_tdata
fft_m_tvalid  in  1
fft_m_tready  out  1
fft_m_tlast  in  1
bin_out  out  DATAWIDTH  output bin
bin_valid  out  1
bin_ready  in  1  downstream ready
bin_index  out  LOG2_LEN  index of bin_out within frame
bin_last  out  1  bin_index == FFT_LEN-1
frame_count  out  16  completed output frames, wraps
overflow  out  1  sticky: sample_valid while FIFO full
err_tlast  out  1  sticky: fft_m_tlast disagrees with bin_last

Behaviour:
- Reset (synchronous, active-high): clk/rst only; FIFO emptied, state = CFG, mode_reg = fwd_inv sampled at reset, in_idx = 0, out_idx = 0, frame_count = 0, overflow = 0, err_tlast = 0.
- Outputs during reset: cfg_tvalid = 0, fft_s_tvalid = 0. In CFG after reset they follow the rules below.
- Config word: cfg_tdata = {7'b0, mode_reg}.
- FSM states:
  - CFG: cfg_tvalid = 1; on cfg_tvalid & cfg_tready go to RUN. fft_s_tvalid is held 0.
  - RUN: fft_s_tvalid = !fifo_empty; cfg_tvalid = 0.
  - At a frame boundary (in_idx == 0, no data handshake this cycle), if fwd_inv != mode_reg: load mode_reg = fwd_inv and go to CFG.
  - A mode change mid-frame is deferred until the current frame completes. Input frames are never split.
- Input FIFO (FWFT):
  - Push when sample_valid & !full. A sample pushed in cycle t is visible on fft_s_tdata in cycle t+1 (no bypass).
  - sample_valid & full: sample dropped, overflow set.
  - Push and pop in the same cycle are allowed when neither full nor empty. Full blocks the push even if a pop occurs that cycle.
- Data handshake:
  - A beat transfers when fft_s_tvalid & fft_s_tready.
  - fft_s_tlast = (in_idx == FFT_LEN-1). in_idx increments per beat and wraps to 0.
  - fft_s_tdata and fft_s_tlast are stable while fft_s_tvalid & !fft_s_tready.
- Output path (combinational passthrough, zero latency):
  - bin_out = fft_m_tdata, bin_valid = fft_m_tvalid, fft_m_tready = bin_ready.
  - bin_index = out_idx, bin_last = (out_idx == FFT_LEN-1).
  - On an output handshake: out_idx increments and wraps. If bin_last, frame_count increments modulo 2**16.
  - If fft_m_tlast != bin_last on a handshake, err_tlast is set. out_idx is not resynchronised.
- Sticky flags clear only on rst.
- Reset mid-frame: all counters return to 0 and a fresh config handshake is issued. Partial frames are discarded, and the parent also resets the core.

Decomposition:
- Package fft_pkg: state enum {CFG, RUN}, CFG_DIR_BIT = 0, CFG_WIDTH = 8.
- Sub-module sync_fifo_fwft (DATAWIDTH, DEPTH): ports push/pop/full/empty/dout, synchronous reset, reusable elsewhere in DATAPATH.
- Top-level counters and FSM stay in fft_stream_framer.

Test Plan (LOG2_LEN=3, FIFO_DEPTH=4):
- Reset with fwd_inv=1, cfg_tready=1 from cycle 2 -> cfg_tdata=8'h01, cfg_tvalid high until the handshake in cycle 2; fft_s_tvalid stays 0 until RUN and FIFO non-empty.
- Stream samples 1..16 with fft_s_tready=1 -> fft_s_tdata 1..16 in order, one cycle after push; fft_s_tlast high on samples 8 and 16 only.
- Hold fft_s_tready=0 while pushing 6 samples -> sample_ready low after 4; overflow=1; samples 5 and 6 absent; data stable during the stall.
- Toggle fwd_inv to 0 at input beat 3 of a frame -> no config until beat 8 transfers, then cfg_tdata=8'h00 handshake, then the next frame streams.
- Drive the core output with 8 bins, tlast on the 8th, bin_ready toggling every cycle -> bin_index 0..7, bin_last only on index 7, frame_count=1, err_tlast=0.
- Drive fft_m_tlast on the 5th bin -> err_tlast=1 and stays 1 until rst; frame_count unaffected until index 7.
